// File: rtl/ext_bus_mem_pkg.sv
// Shared definitions for the external bus: header layout, burst geometry and FSM states.
// Imported by both bus endpoints so the header decode stays in one place.
package ext_bus_mem_pkg;

  // Cache-line size exponent in bytes; a burst covers one line of 32-bit words.
  localparam int unsigned CLSIZE_E  = 6;
  localparam int unsigned COUNT_LEN = CLSIZE_E - 2;
  localparam int unsigned BURST_LEN = 1 << COUNT_LEN;

  typedef struct packed {
    logic        is_write;
    logic [1:0]  size;
    logic [28:0] addr;
  } bus_addr_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2
  } state_e;

  // Byte-lane enables for a write of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001 << off;
      2'd1:    m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ext_bus_ram.sv
// Byte-lane writable word array: one masked write port, one combinational read port.
// Contents are deliberately not reset.
module ext_bus_ram #(
  parameter int unsigned Words = 1024,
  parameter int unsigned AddrW = $clog2(Words)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [3:0]       wmask_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Words];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_i[i]) begin
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ext_bus_mem.sv
// Bus-attached memory endpoint: accepts a header, then serves single or wrapping burst
// reads/writes against a byte-lane writable array, one beat per cycle.
module ext_bus_mem
  import ext_bus_mem_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_busOE,
  input  logic [WIDTH-1:0] IN_bus,
  input  logic             IN_busValid,
  output logic [WIDTH-1:0] OUT_bus,
  output logic             OUT_busReady,
  input  logic             IN_stall
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = COUNT_LEN + 1;

  state_e         state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     size_q, size_d;
  logic [1:0]     off_q, off_d;
  logic [31:0]    data_q, data_d;
  logic           full_q, full_d;

  bus_addr_t      hdr;
  logic [AW-1:0]  hdr_idx;
  logic [AW-1:0]  idx_inc;
  logic           xfer;
  logic           last_beat;
  logic           ram_we;
  logic [AW-1:0]  ram_raddr;
  logic [31:0]    ram_rdata;
  logic           unused_hdr_bits;

  assign hdr             = bus_addr_t'(IN_bus[31:0]);
  assign hdr_idx         = hdr.addr[AW+1:2];
  assign unused_hdr_bits = ^hdr.addr[28:AW+2];
  // Only the in-line offset advances; the line base is kept so bursts wrap.
  assign idx_inc   = {idx_q[AW-1:COUNT_LEN], idx_q[COUNT_LEN-1:0] + COUNT_LEN'(1)};
  assign xfer      = IN_busValid & OUT_busReady;
  assign last_beat = (cnt_q == CW'(1));

  assign ram_we    = (state_q == StWrite) && xfer;
  // In IDLE the read port looks at the incoming header so the first word is ready next cycle.
  assign ram_raddr = (state_q == StIdle) ? hdr_idx : idx_inc;

  ext_bus_ram #(
    .Words(MEM_WORDS)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .wmask_i (lane_mask(size_q, off_q)),
    .waddr_i (idx_q),
    .wdata_i (IN_bus[31:0]),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      off_q   <= '0;
      data_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      off_q   <= off_d;
      data_q  <= data_d;
      full_q  <= full_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (xfer) state_d = hdr.is_write ? StWrite : StRead;
      end
      StRead, StWrite: begin
        if (xfer && last_beat) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    size_d = size_q;
    off_d  = off_q;
    data_d = data_q;
    full_d = full_q;
    case (state_q)
      StIdle: begin
        if (xfer) begin
          idx_d  = hdr_idx;
          cnt_d  = (hdr.size == 2'd3) ? CW'(BURST_LEN) : CW'(1);
          size_d = hdr.size;
          off_d  = hdr.addr[1:0];
          if (!hdr.is_write) begin
            data_d = ram_rdata;
            full_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (xfer) begin
          idx_d = idx_inc;
          cnt_d = cnt_q - CW'(1);
          if (last_beat) full_d = 1'b0;
          else           data_d = ram_rdata;
        end
      end
      StWrite: begin
        if (xfer) begin
          idx_d = idx_inc;
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: full_d = 1'b0;
    endcase
  end

  // Outputs
  always_comb begin
    OUT_busReady = 1'b0;
    case (state_q)
      StIdle:  OUT_busReady = IN_busOE & ~IN_stall;
      StRead:  OUT_busReady = full_q & ~IN_stall;
      StWrite: OUT_busReady = ~IN_stall;
      default: OUT_busReady = 1'b0;
    endcase
    // Reset drops ready combinationally, before the asynchronous state clear settles.
    if (rst) OUT_busReady = 1'b0;
    OUT_bus = '0;
    if (state_q == StRead && OUT_busReady) OUT_bus[31:0] = data_q;
  end

endmodule
